// File: rtl/tank_pkg.sv
// Shared constants for the tank level responder: level width, mode encodings,
// default tick counts and the input-to-mode selection rule.
package tank_pkg;

   localparam int LEVEL_W = 3;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_FILL  = 2'b01;
   localparam logic [1:0] MODE_DRAIN = 2'b10;
   localparam logic [1:0] MODE_CLEAN = 2'b11;

   localparam int DEF_FILL_TICKS  = 4;
   localparam int DEF_DRAIN_TICKS = 6;
   localparam int DEF_LIMP_TICKS  = 2;

   // Inlet against any consumer nets to zero flow; cleaning outranks mixing.
   function automatic logic [1:0] select_mode(input logic ve, input logic mist, input logic limp);
      logic [1:0] m;
      m = MODE_IDLE;
      if (ve && !mist && !limp) begin
         m = MODE_FILL;
      end else if (!ve && limp) begin
         m = MODE_CLEAN;
      end else if (!ve && mist) begin
         m = MODE_DRAIN;
      end
      return m;
   endfunction

   function automatic int count_width(input int max_ticks);
      int w;
      w = $clog2(max_ticks);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/tank_prescaler.sv
// Per-mode tick prescaler: restarts on every mode change or in IDLE and
// flags the cycle on which the mode's count wraps.
module tank_prescaler
   import tank_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] ticks_m1,
   output logic             wrap
);

   logic [1:0]       prev_mode;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] base;
   logic             active;
   logic             at_end;

   // A mode change counts its own edge as the first tick of the new mode.
   always_comb begin
      base   = (mode != prev_mode) ? '0 : count;
      active = (mode != MODE_IDLE);
      at_end = (base == ticks_m1);
      wrap   = active && at_end;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_mode <= MODE_IDLE;
         count     <= '0;
      end else begin
         prev_mode <= mode;
         if (!active || at_end) begin
            count <= '0;
         end else begin
            count <= base + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tank_level_resp.sv
// Tank level responder: integrates fill/drain/clean activity into a 3-bit level.
// Optional sticky overfill flag enabled by defining TANK_OVF_FLAG_EN.
module tank_level_resp
   import tank_pkg::*;
#(
   parameter int FILL_TICKS  = DEF_FILL_TICKS,
   parameter int DRAIN_TICKS = DEF_DRAIN_TICKS,
   parameter int LIMP_TICKS  = DEF_LIMP_TICKS,
   parameter int LEVEL_MAX   = 5,
   parameter int LEVEL_INIT  = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic Ve,
   input  logic Mist,
   input  logic Limp,
   output logic Nv2,
   output logic Nv1,
   output logic Nv0,
   output logic Full,
   output logic Empty,
   output logic Ovf
);

   localparam int MAX_TICKS_FD = (FILL_TICKS > DRAIN_TICKS) ? FILL_TICKS : DRAIN_TICKS;
   localparam int MAX_TICKS    = (MAX_TICKS_FD > LIMP_TICKS) ? MAX_TICKS_FD : LIMP_TICKS;
   localparam int CNT_W        = count_width(MAX_TICKS);

   localparam logic [CNT_W-1:0]   FILL_M1  = CNT_W'(FILL_TICKS - 1);
   localparam logic [CNT_W-1:0]   DRAIN_M1 = CNT_W'(DRAIN_TICKS - 1);
   localparam logic [CNT_W-1:0]   LIMP_M1  = CNT_W'(LIMP_TICKS - 1);
   localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
   localparam logic [LEVEL_W-1:0] LVL_INIT = LEVEL_W'(LEVEL_INIT);

   logic [1:0]         mode;
   logic [CNT_W-1:0]   ticks_m1;
   logic               step;
   logic [LEVEL_W-1:0] level;
   logic [LEVEL_W-1:0] level_next;

   always_comb begin
      mode = select_mode(Ve, Mist, Limp);
      case (mode)
         MODE_FILL:  ticks_m1 = FILL_M1;
         MODE_DRAIN: ticks_m1 = DRAIN_M1;
         MODE_CLEAN: ticks_m1 = LIMP_M1;
         default:    ticks_m1 = '0;
      endcase
   end

   tank_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .ticks_m1 (ticks_m1),
      .wrap     (step)
   );

   // Level saturates at both ends; the prescaler keeps wrapping regardless.
   always_comb begin
      level_next = level;
      if (step) begin
         case (mode)
            MODE_FILL: begin
               if (level != LVL_MAX) begin
                  level_next = level + 1'b1;
               end
            end
            MODE_DRAIN, MODE_CLEAN: begin
               if (level != '0) begin
                  level_next = level - 1'b1;
               end
            end
            default: level_next = level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level <= LVL_INIT;
         Full  <= (LVL_INIT == LVL_MAX);
         Empty <= (LVL_INIT == '0);
      end else begin
         level <= level_next;
         Full  <= (level_next == LVL_MAX);
         Empty <= (level_next == '0);
      end
   end

   assign Nv2 = level[2];
   assign Nv1 = level[1];
   assign Nv0 = level[0];

`ifdef TANK_OVF_FLAG_EN
   logic ovf_flag;

   // Sticky: a fill wrap against a full tank means the inlet is overfilling.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_flag <= 1'b0;
      end else if (step && (mode == MODE_FILL) && (level == LVL_MAX)) begin
         ovf_flag <= 1'b1;
      end
   end

   assign Ovf = ovf_flag;
`else
   assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_tank_level_resp.sv
// Directed bench for tank_level_resp with default parameters; overfill
// expectations follow whether TANK_OVF_FLAG_EN is defined.
module tb_tank_level_resp;

`ifdef TANK_OVF_FLAG_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic clk;
   logic reset;
   logic Ve;
   logic Mist;
   logic Limp;
   logic Nv2;
   logic Nv1;
   logic Nv0;
   logic Full;
   logic Empty;
   logic Ovf;

   int compared;
   int mismatched;

   tank_level_resp dut (
      .clk   (clk),
      .reset (reset),
      .Ve    (Ve),
      .Mist  (Mist),
      .Limp  (Limp),
      .Nv2   (Nv2),
      .Nv1   (Nv1),
      .Nv0   (Nv0),
      .Full  (Full),
      .Empty (Empty),
      .Ovf   (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ve, input logic mist, input logic limp, input int edges);
      reset = rst;
      Ve    = ve;
      Mist  = mist;
      Limp  = limp;
      for (int i = 0; i < edges; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] nv();
      return {5'b0, Nv2, Nv1, Nv0};
   endfunction

   initial begin
      compared   = 0;
      mismatched = 0;
      reset = 1'b1;
      Ve    = 1'b0;
      Mist  = 1'b0;
      Limp  = 1'b0;
      #2;

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2);
      checkOutput("reset_nv", nv(), 8'd0);
      checkOutput("reset_empty", {7'b0, Empty}, 8'd1);
      checkOutput("reset_full", {7'b0, Full}, 8'd0);
      checkOutput("reset_ovf", {7'b0, Ovf}, 8'd0);

      // Fill from empty to full
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("fill_e3", nv(), 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("fill_e4", nv(), 8'd1);
      checkOutput("fill_e4_empty", {7'b0, Empty}, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4);
      checkOutput("fill_e8", nv(), 8'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11);
      checkOutput("fill_e19", nv(), 8'd4);
      checkOutput("fill_e19_full", {7'b0, Full}, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("fill_e20", nv(), 8'd5);
      checkOutput("fill_e20_full", {7'b0, Full}, 8'd1);
      checkOutput("fill_e20_ovf", {7'b0, Ovf}, 8'd0);

      // Overfill at full level
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("ovf_e3", {7'b0, Ovf}, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("ovf_e4", {7'b0, Ovf}, {7'b0, OVF_EXP});
      checkOutput("ovf_e4_nv", nv(), 8'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);
      checkOutput("ovf_sticky", {7'b0, Ovf}, {7'b0, OVF_EXP});

      // Mixer drain from full
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
      checkOutput("drain_e5", nv(), 8'd5);
      checkOutput("drain_e5_full", {7'b0, Full}, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("drain_e6", nv(), 8'd4);
      checkOutput("drain_e6_full", {7'b0, Full}, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6);
      checkOutput("drain_e12", nv(), 8'd3);

      // Inlet against mixer holds level, and the prescaler restarts
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10);
      checkOutput("net_zero", nv(), 8'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5);
      checkOutput("restart_e5", nv(), 8'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("restart_e6", nv(), 8'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8);
      checkOutput("ve_limp_idle", nv(), 8'd2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6);
      checkOutput("drain_to1", nv(), 8'd1);

      // Cleaning outranks mixing and saturates at empty
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1);
      checkOutput("clean_e1", nv(), 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1);
      checkOutput("clean_e2", nv(), 8'd0);
      checkOutput("clean_e2_empty", {7'b0, Empty}, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2);
      checkOutput("clean_e4", nv(), 8'd0);
      checkOutput("clean_e4_empty", {7'b0, Empty}, 8'd1);
      checkOutput("ovf_survives", {7'b0, Ovf}, {7'b0, OVF_EXP});

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("reset_clears_ovf", {7'b0, Ovf}, 8'd0);

      // Reset mid-step discards partial progress
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("midreset_nv", nv(), 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("midreset_e3", nv(), 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("midreset_e4", nv(), 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/tank_level_resp.md
TANK_LEVEL_RESP -- requirements
Module: tank_level_resp

Interface
REQ-001 Parameter FILL_TICKS, default 4: consecutive Ve-high cycles per one-step level rise.
REQ-002 Parameter DRAIN_TICKS, default 6: consecutive Mist-only cycles per one-step level fall.
REQ-003 Parameter LIMP_TICKS, default 2: consecutive Limp-high cycles per one-step level fall.
REQ-004 Parameter LEVEL_MAX, default 5: full-tank level code, range 1..7.
REQ-005 Parameter LEVEL_INIT, default 0: level loaded on reset, range 0..LEVEL_MAX.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 Ve  input  1  inlet valve open (fill command).
REQ-009 Mist  input  1  mixer running (normal consumption).
REQ-010 Limp  input  1  cleaning cycle running (fast drain).
REQ-011 Nv2, Nv1, Nv0  output  1 each  registered level code {Nv2,Nv1,Nv0}, binary, 000 = empty.
REQ-012 Full  output  1  registered; high when level == LEVEL_MAX.
REQ-013 Empty  output  1  registered; high when level == 0.
REQ-014 Ovf  output  1  sticky overfill flag (see Configuration).

Function
REQ-015 Internal state: 3-bit level, prescaler counter wide enough for the largest TICKS parameter, 2-bit mode register.
REQ-016 Modes: IDLE, FILL, DRAIN, CLEAN. Mode selected each cycle from inputs: Ve with neither Mist nor Limp -> FILL; Limp without Ve -> CLEAN; Mist without Ve or Limp -> DRAIN; all other combinations -> IDLE.
REQ-017 Ve together with Mist or Limp -> IDLE (net flow zero); level held.
REQ-018 Mist and Limp both high without Ve -> CLEAN; Limp rate wins.
REQ-019 Prescaler clears to 0 whenever the selected mode differs from the previous cycle's mode, and in IDLE.
REQ-020 In FILL/DRAIN/CLEAN, the prescaler increments each cycle; when it equals the mode's TICKS-1, it wraps to 0 and level steps by one.
REQ-021 Latency: after N consecutive edges in one active mode, the outputs show floor(N/TICKS) steps, visible immediately after the N-th edge.
REQ-022 Level saturates: FILL at LEVEL_MAX does not increment; DRAIN/CLEAN at 0 do not decrement; the prescaler continues wrapping.
REQ-023 Full, Empty, and Nv2..Nv0 are derived from the registered level and update on the same edge as the level.

Reset
REQ-024 On an edge with reset high: level = LEVEL_INIT, prescaler = 0, mode = IDLE, Ovf = 0; inputs ignored that cycle.
REQ-025 Reset mid-step discards partial prescaler progress; the next step needs a full TICKS count.

Configuration
REQ-026 Macro TANK_OVF_FLAG_EN defined: Ovf sets when the FILL prescaler wraps while level == LEVEL_MAX, and stays high until reset.
REQ-027 Macro TANK_OVF_FLAG_EN undefined: Ovf is driven constant 0, and no flag register is synthesised; the port remains.

Structure
REQ-028 Package tank_pkg holds the level width (3), the mode encoding constants (IDLE=00, FILL=01, DRAIN=10, CLEAN=11), and the default TICKS values.
REQ-029 One sub-module, tank_prescaler, holds the counter, clear-on-mode-change, and terminal-count pulse; the top holds mode selection, level, and flags.

Verification (defaults, TANK_OVF_FLAG_EN defined)
REQ-030 Reset, then Ve=1 for 20 edges -> Nv=001 after edge 4, 010 after edge 8, 101 and Full=1 after edge 20.
REQ-031 Level 5, Mist=1 for 12 edges -> Nv=100 after edge 6, 011 after edge 12; Full drops after edge 6.
REQ-032 Level 1, Mist=1 and Limp=1 for 4 edges -> Nv=000 and Empty=1 after edge 2; level stays at 000 after edge 4.
REQ-033 Level 3, Ve=1 and Mist=1 for 10 edges -> Nv stays 011 and the prescaler stays 0.
REQ-034 Reset, Ve=1 for 3 edges, reset for 1 edge, Ve=1 for 3 edges -> Nv stays 000; 1 more Ve edge -> Nv=001.
REQ-035 Level 5, Ve=1 for 4 edges -> Ovf=1 after edge 4 and Nv stays 101; Ve=0 for 10 edges -> Ovf still 1; reset -> Ovf=0.
